// File: rtl/vpu_dma.sv
// VPU DMA initiator: programs AutoOffset and VRAM address, then streams data-port
// writes from system memory (copy) or a constant (fill), relying on VPU auto-increment.
module vpu_dma #(
    parameter int WR_GAP = 2,
    parameter int SRC_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [12:0]      i_dst_addr,
    input  logic [SRC_W-1:0] i_src_addr,
    input  logic [12:0]      i_len,
    input  logic [7:0]       i_step,
    input  logic [7:0]       i_fill_byte,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mem_rd,
    output logic [SRC_W-1:0] o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [7:0]       i_mem_di,
    output logic             o_vpu_cs,
    output logic             o_vpu_rw,
    output logic [3:0]       o_vpu_ad,
    output logic [7:0]       o_vpu_do
);

    // state   | meaning
    // IDLE    | waiting for start
    // SET_OFS | strobe AutoOffset ($5)
    // OFS_W   | idle cycle after $5
    // SET_HI  | strobe VRAM address high ($2)
    // HI_W    | idle cycle after $2
    // SET_LO  | strobe VRAM address low ($3)
    // LO_W    | idle cycle after $3
    // FETCH   | memory read outstanding (copy only)
    // WRITE   | strobe data port ($0)
    // GAP     | WR_GAP idle cycles for the VPU write pipeline
    // FIN     | one-cycle done pulse
    typedef enum logic [3:0] {
        ST_IDLE, ST_SET_OFS, ST_OFS_W, ST_SET_HI, ST_HI_W, ST_SET_LO, ST_LO_W,
        ST_FETCH, ST_WRITE, ST_GAP, ST_FIN
    } state_t;

    localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [12:0]      r_cnt;
    logic [SRC_W-1:0] r_src;
    logic             r_mode;
    logic [12:0]      r_dst;
    logic [7:0]       r_fill;
    logic [GAP_W-1:0] r_gap;

    logic             r_busy, r_done, r_mem_rd, r_cs, r_rw;
    logic [3:0]       r_ad;
    logic [7:0]       r_do;
    logic             w_busy, w_done, w_mem_rd, w_cs;
    logic [3:0]       w_ad;
    logic [7:0]       w_do;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) begin
            if (i_start) w_next = (i_len == 13'd0) ? ST_FIN : ST_SET_OFS;
        end else if (r_state == ST_FIN) begin
            w_next = ST_IDLE;
        end else if (i_abort) begin
            w_next = ST_FIN;
        end else begin
            case (r_state)
                ST_SET_OFS: w_next = ST_OFS_W;
                ST_OFS_W:   w_next = ST_SET_HI;
                ST_SET_HI:  w_next = ST_HI_W;
                ST_HI_W:    w_next = ST_SET_LO;
                ST_SET_LO:  w_next = ST_LO_W;
                ST_LO_W:    w_next = r_mode ? ST_FETCH : ST_WRITE;
                ST_FETCH:   if (i_mem_ack) w_next = ST_WRITE;
                ST_WRITE:   w_next = ST_GAP;
                ST_GAP: begin
                    if (r_gap == '0) begin
                        if (r_cnt == 13'd0) w_next = ST_FIN;
                        else                w_next = r_mode ? ST_FETCH : ST_WRITE;
                    end
                end
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they line up with r_state.
    always_comb begin
        w_cs     = 1'b0;
        w_ad     = r_ad;
        w_do     = r_do;
        w_mem_rd = (w_next == ST_FETCH);
        w_busy   = (w_next != ST_IDLE) && (w_next != ST_FIN);
        w_done   = (w_next == ST_FIN);
        case (w_next)
            ST_SET_OFS: begin w_cs = 1'b1; w_ad = 4'h5; w_do = i_step; end
            ST_SET_HI:  begin w_cs = 1'b1; w_ad = 4'h2; w_do = {3'b000, r_dst[12:8]}; end
            ST_SET_LO:  begin w_cs = 1'b1; w_ad = 4'h3; w_do = r_dst[7:0]; end
            ST_WRITE:   begin w_cs = 1'b1; w_ad = 4'h0; w_do = r_mode ? i_mem_di : r_fill; end
            default:    ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mem_rd <= 1'b0;
            r_cs     <= 1'b0;
            r_rw     <= 1'b1;
            r_ad     <= 4'h0;
            r_do     <= 8'h00;
        end else begin
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_mem_rd <= w_mem_rd;
            r_cs     <= w_cs;
            r_rw     <= ~w_cs;
            r_ad     <= w_ad;
            r_do     <= w_do;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= 13'd0;
            r_src  <= '0;
            r_mode <= 1'b0;
            r_dst  <= 13'd0;
            r_fill <= 8'h00;
            r_gap  <= '0;
        end else begin
            if (r_state == ST_IDLE && i_start) begin
                r_cnt  <= i_len;
                r_src  <= i_src_addr;
                r_mode <= i_mode;
                r_dst  <= i_dst_addr;
                r_fill <= i_fill_byte;
            end
            if (r_state == ST_FETCH && i_mem_ack && !i_abort) r_src <= r_src + SRC_W'(1);
            if (r_state == ST_WRITE) begin
                r_cnt <= r_cnt - 13'd1;
                r_gap <= GAP_W'(WR_GAP - 1);
            end
            if (r_state == ST_GAP && r_gap != '0) r_gap <= r_gap - GAP_W'(1);
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_mem_rd   = r_mem_rd;
    assign o_mem_addr = r_src;
    assign o_vpu_cs   = r_cs;
    assign o_vpu_rw   = r_rw;
    assign o_vpu_ad   = r_ad;
    assign o_vpu_do   = r_do;

endmodule

// File: tb/tb_vpu_dma.sv
// Bench for vpu_dma: directed table, corner sequences and random transfers checked
// against a transfer-level model (expected strobe list, latency, VRAM image).
module tb_vpu_dma;
    logic        clk = 1'b0;
    logic        rst_n, start, mode, abort, mem_ack;
    logic [12:0] dst, len;
    logic [15:0] src, mem_addr;
    logic [7:0]  step, fill, mem_di, vpu_do;
    logic        busy, done, mem_rd, vpu_cs, vpu_rw;
    logic [3:0]  vpu_ad;

    always #5 clk = ~clk;

    vpu_dma #(.WR_GAP(2), .SRC_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode),
        .i_dst_addr(dst), .i_src_addr(src), .i_len(len), .i_step(step),
        .i_fill_byte(fill), .i_abort(abort), .o_busy(busy), .o_done(done),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack),
        .i_mem_di(mem_di), .o_vpu_cs(vpu_cs), .o_vpu_rw(vpu_rw),
        .o_vpu_ad(vpu_ad), .o_vpu_do(vpu_do)
    );

    typedef struct {
        logic        mode;
        logic [12:0] dst;
        logic [15:0] src;
        logic [12:0] len;
        logic [7:0]  step;
        logic [7:0]  fill;
        int          lat;
    } cfg_t;

    typedef struct {
        cfg_t c;
        int   exp_lat;
        int   exp_strb;
    } vec_t;

    int          n_cmp = 0, n_bad = 0;
    logic [7:0]  mem  [0:65535];
    logic [7:0]  vram [0:8191];
    logic [11:0] got [$];
    int          cyc = 0, n_done = 0, done_cyc = 0, n_memrd = 0, n_rise = 0;
    int          lat_cur = 1, wcnt = 0;
    logic        prev_cs = 1'b0, prev_rd = 1'b0;
    logic [12:0] vaddr = 13'd0;
    logic [7:0]  vofs = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory responder, VPU register model and strobe monitor.
    always @(negedge clk) begin
        cyc++;
        if (mem_rd) begin
            n_memrd++;
            wcnt++;
            if (!prev_rd) n_rise++;
            if (wcnt == lat_cur) begin
                mem_ack = 1'b1;
                mem_di  = mem[mem_addr];
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            wcnt    = 0;
            mem_ack = 1'b0;
        end
        prev_rd = mem_rd;
        if (vpu_cs) begin
            chk("cs_single_cycle", 32'(prev_cs), 32'd0);
            chk("rw_low_with_cs", 32'(vpu_rw), 32'd0);
            got.push_back({vpu_ad, vpu_do});
            case (vpu_ad)
                4'h5: vofs = vpu_do;
                4'h2: vaddr[12:8] = vpu_do[4:0];
                4'h3: vaddr[7:0] = vpu_do;
                4'h0: begin
                    vram[vaddr] = vpu_do;
                    vaddr = vaddr + 13'(vofs);
                end
                default: ;
            endcase
        end
        prev_cs = vpu_cs;
        if (done) begin
            n_done++;
            done_cyc = cyc;
            chk("busy_low_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_cfg(input cfg_t c);
        mode = c.mode; dst = c.dst; src = c.src; len = c.len;
        step = c.step; fill = c.fill; lat_cur = c.lat;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (n_done > 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("done_within_budget", 32'(n_done), 32'd1);
    endtask

    task automatic run(input cfg_t c, input int exp_lat, input int exp_strb, input bit poke);
        logic [11:0] exp_q [$];
        logic [7:0]  img [int];
        logic [7:0]  b;
        logic [15:0] a16;
        logic [12:0] a13;
        int          st, model_lat, exp_rd;
        bit          ok;
        got.delete();
        n_done  = 0;
        n_memrd = 0;
        drive_cfg(c);
        start = 1'b1;
        st = cyc;
        tick();
        start = 1'b0;
        if (poke) begin
            chk("busy_during_xfer", 32'(busy), 32'd1);
            mode = ~c.mode; dst = ~c.dst; src = ~c.src; len = 13'd7;
            step = ~c.step; fill = ~c.fill;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(3000, ok);
        if (ok) begin
            model_lat = (c.len == 0) ? 1 : 7 + int'(c.len) * (c.mode ? c.lat + 3 : 3);
            chk("done_latency", 32'(done_cyc - st), 32'((exp_lat >= 0) ? exp_lat : model_lat));
            tick();
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("done_one_cycle", 32'(done), 32'd0);
            if (c.len != 0) begin
                exp_q.push_back({4'h5, c.step});
                exp_q.push_back({4'h2, 3'b000, c.dst[12:8]});
                exp_q.push_back({4'h3, c.dst[7:0]});
            end
            for (int i = 0; i < int'(c.len); i++) begin
                a16 = c.src + 16'(i);
                b   = c.mode ? mem[a16] : c.fill;
                exp_q.push_back({4'h0, b});
                a13 = c.dst + 13'(i * int'(c.step));
                img[int'(a13)] = b;
            end
            chk("strobe_count", 32'(got.size()), 32'(exp_q.size()));
            if (exp_strb >= 0) chk("strobe_count_table", 32'(got.size()), 32'(exp_strb));
            for (int i = 0; i < exp_q.size() && i < got.size(); i++)
                chk("strobe", 32'(got[i]), 32'(exp_q[i]));
            exp_rd = c.mode ? int'(c.len) * c.lat : 0;
            chk("mem_rd_cycles", 32'(n_memrd), 32'(exp_rd));
            foreach (img[k]) chk("vram", 32'(vram[k]), 32'(img[k]));
        end
    endtask

    vec_t vec [7];
    cfg_t cr;
    bit   ok, pk;
    int   st, ndata;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
        mem[16'h2000] = 8'h11;
        mem[16'h2001] = 8'h22;
        vec[0] = '{'{1'b0, 13'h0100, 16'h0000, 13'd3, 8'h01, 8'hAA, 1}, 16, 6};
        vec[1] = '{'{1'b1, 13'h0040, 16'h2000, 13'd2, 8'h01, 8'h00, 3}, 19, 5};
        vec[2] = '{'{1'b0, 13'h0200, 16'h0000, 13'd0, 8'h01, 8'h33, 1},  1, 0};
        vec[3] = '{'{1'b0, 13'h1FFF, 16'h0000, 13'd2, 8'h01, 8'h5C, 1}, 13, 5};
        vec[4] = '{'{1'b1, 13'h0300, 16'hFFFF, 13'd1, 8'h02, 8'h00, 1}, 11, 4};
        vec[5] = '{'{1'b1, 13'h0400, 16'h1234, 13'd0, 8'h01, 8'h00, 2},  1, 0};
        vec[6] = '{'{1'b0, 13'h1FFE, 16'h0000, 13'd4, 8'h03, 8'h0F, 1}, 19, 7};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mem_ack = 1'b0; mem_di = 8'h00;
        mode = 1'b0; dst = '0; src = '0; len = '0; step = '0; fill = '0;
        tick(); tick();
        chk("reset_ctl", 32'({busy, done, mem_rd, vpu_cs, vpu_rw}), 32'(5'b00001));
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_vpu", 32'({vpu_ad, vpu_do}), 32'd0);
        rst_n = 1'b1;
        tick();

        foreach (vec[i]) run(vec[i].c, vec[i].exp_lat, vec[i].exp_strb, 1'b0);

        // start while busy is dropped
        run('{1'b0, 13'h0ABC, 16'h0000, 13'd2, 8'h02, 8'h77, 1}, -1, 5, 1'b1);

        // abort in the 2nd FETCH of a 5-byte copy, then start in FIN is ignored
        got.delete(); n_done = 0; n_rise = 0;
        drive_cfg('{1'b1, 13'h0500, 16'h3000, 13'd5, 8'h01, 8'h00, 4});
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && n_rise < 2; i++) tick();
        chk("second_fetch_seen", 32'(n_rise), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_mem_rd_drop", 32'(mem_rd), 32'd0);
        chk("abort_done_pulse", 32'(done), 32'd1);
        ndata = 0;
        foreach (got[i]) if (got[i][11:8] == 4'h0) ndata++;
        chk("abort_data_writes", 32'(ndata), 32'd1);
        drive_cfg('{1'b0, 13'h0600, 16'h0000, 13'd1, 8'h01, 8'h44, 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_fin_ignored", 32'({busy, vpu_cs}), 32'd0);
        chk("abort_done_count", 32'(n_done), 32'd1);
        run('{1'b0, 13'h0600, 16'h0000, 13'd1, 8'h01, 8'h44, 1}, 10, 4, 1'b0);

        // abort together with start in IDLE: start wins, abort ends it after SET_OFS
        got.delete(); n_done = 0;
        drive_cfg('{1'b0, 13'h0700, 16'h0000, 13'd3, 8'h09, 8'h12, 1});
        start = 1'b1; abort = 1'b1;
        st = cyc;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_start_done", 32'(n_done), 32'd1);
        chk("abort_start_latency", 32'(done_cyc - st), 32'd2);
        chk("abort_start_strobes", 32'(got.size()), 32'd1);
        chk("abort_start_ofs", 32'((got.size() > 0) ? got[0] : 12'hFFF), 32'(12'h509));
        tick();

        // asynchronous reset during GAP
        got.delete(); n_done = 0;
        drive_cfg('{1'b0, 13'h0800, 16'h0000, 13'd3, 8'h01, 8'h66, 1});
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("gap_strobes_so_far", 32'(got.size()), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 32'({busy, done, mem_rd, vpu_cs, vpu_rw}), 32'(5'b00001));
        chk("async_reset_vpu", 32'({vpu_ad, vpu_do}), 32'd0);
        repeat (4) tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("no_done_after_reset", 32'(n_done), 32'd0);
        chk("no_strobe_after_reset", 32'(got.size()), 32'd4);

        for (int k = 0; k < 15; k++) begin
            cr.mode = 1'($urandom);
            cr.dst  = 13'($urandom);
            cr.src  = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            cr.len  = 13'($urandom_range(0, 6));
            cr.step = 8'($urandom);
            cr.fill = 8'($urandom);
            cr.lat  = int'($urandom_range(1, 4));
            pk = (cr.len != 0) && ($urandom_range(0, 2) == 0);
            run(cr, -1, -1, pk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
